// File: rtl/bc_pkg.sv
// Character-code constants shared by the display scanner and the game FSM.
`default_nettype none

package bc_pkg;

  localparam int CODE_W     = 5;
  localparam int NUM_DIGITS = 8;

  typedef logic [CODE_W-1:0] code_t;

  // Codes 0x00-0x0F are the hex glyphs; these name the letter/blank codes.
  localparam code_t CH_BLANK = 5'h10;
  localparam code_t CH_J     = 5'h11;
  localparam code_t CH_S     = 5'h12;
  localparam code_t CH_T     = 5'h13;
  localparam code_t CH_U     = 5'h14;
  localparam code_t CH_P     = 5'h15;
  localparam code_t CH_G     = 5'h16;
  localparam code_t CH_L     = 5'h17;
  localparam code_t CH_Y     = 5'h18;
  localparam code_t CH_N     = 5'h19;

endpackage

`default_nettype wire

// File: rtl/char_to_seg.sv
// Combinational character-code to active-low seven-segment decoder.
`default_nettype none

module char_to_seg
  import bc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [6:0]        seg
);

  // Patterns are written active-high (bit 0 = a .. bit 6 = g) and inverted once.
  logic [6:0] lit;

  always_comb begin
    lit = 7'h00;
    case (code)
      5'h00:    lit = 7'h3F;
      5'h01:    lit = 7'h06;
      5'h02:    lit = 7'h5B;
      5'h03:    lit = 7'h4F;
      5'h04:    lit = 7'h66;
      5'h05:    lit = 7'h6D;
      5'h06:    lit = 7'h7D;
      5'h07:    lit = 7'h07;
      5'h08:    lit = 7'h7F;
      5'h09:    lit = 7'h6F;
      5'h0A:    lit = 7'h77;
      5'h0B:    lit = 7'h7C;
      5'h0C:    lit = 7'h39;
      5'h0D:    lit = 7'h5E;
      5'h0E:    lit = 7'h79;
      5'h0F:    lit = 7'h71;
      CH_J:     lit = 7'h1E;
      CH_S:     lit = 7'h6D;
      CH_T:     lit = 7'h78;
      CH_U:     lit = 7'h3E;
      CH_P:     lit = 7'h73;
      CH_G:     lit = 7'h3D;
      CH_L:     lit = 7'h38;
      CH_Y:     lit = 7'h6E;
      CH_N:     lit = 7'h54;
      default:  lit = 7'h00;
    endcase
  end

  assign seg = ~lit;

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous
// double-buffered loads, per-digit blink and anti-ghosting guard blanking.
`default_nettype none

module seven_seg_scan
  import bc_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_DIGITS*CODE_W-1:0] chars_in,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  input  logic [NUM_DIGITS-1:0]        blink_in,
  input  logic                         load,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic                         frame_done
);

  localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SLOT_W-1:0]            slot_cnt;
  logic [2:0]                   idx;
  logic [BLINK_W-1:0]           blink_cnt;
  logic                         blink_phase;

  logic [NUM_DIGITS*CODE_W-1:0] act_chars;
  logic [NUM_DIGITS-1:0]        act_dp;
  logic [NUM_DIGITS-1:0]        act_blink;
  logic [NUM_DIGITS*CODE_W-1:0] pend_chars;
  logic [NUM_DIGITS-1:0]        pend_dp;
  logic [NUM_DIGITS-1:0]        pend_blink;
  logic                         pend_valid;

  logic                         slot_tc;
  logic                         boundary;
  logic                         in_guard;
  logic                         dark;
  logic [CODE_W-1:0]            cur_code;
  logic [6:0]                   cur_seg;

  assign slot_tc  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
  assign boundary = slot_tc && (idx == 3'd7);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (slot_cnt < SLOT_W'(GUARD));
    end
  endgenerate

  assign dark     = in_guard || (blink_phase && act_blink[idx]);
  assign cur_code = act_chars[idx*CODE_W +: CODE_W];

  char_to_seg u_dec (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= 3'd0;
    end else if (slot_tc) begin
      slot_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  // Active data changes only at a frame boundary so no frame mixes old and new.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_chars  <= {NUM_DIGITS{CH_BLANK}};
      act_dp     <= '0;
      act_blink  <= '0;
      pend_chars <= {NUM_DIGITS{CH_BLANK}};
      pend_dp    <= '0;
      pend_blink <= '0;
      pend_valid <= 1'b0;
    end else if (load && boundary) begin
      act_chars  <= chars_in;
      act_dp     <= dp_in;
      act_blink  <= blink_in;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_chars <= chars_in;
      pend_dp    <= dp_in;
      pend_blink <= blink_in;
      pend_valid <= 1'b1;
    end else if (boundary && pend_valid) begin
      act_chars  <= pend_chars;
      act_dp     <= pend_dp;
      act_blink  <= pend_blink;
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (dark) begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= cur_seg;
        dp  <= ~act_dp[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan with a cycle-count-based reference model.
`default_nettype none

module tb_seven_seg_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [39:0] chars_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blink_in = '0;
  logic        load = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];

  // Reference state: cyc is the scan state that the next rising edge samples.
  int         cyc = 0;
  logic [4:0] m_act [8];
  logic [4:0] m_pend [8];
  logic [7:0] m_dp, m_blink, m_pdp, m_pblink;
  bit         m_pv;

  seven_seg_scan #(
    .REFRESH_DIV (8),
    .GUARD       (2),
    .BLINK_DIV   (64)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .chars_in   (chars_in),
    .dp_in      (dp_in),
    .blink_in   (blink_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'h00: glyph = 7'h40;  5'h01: glyph = 7'h79;  5'h02: glyph = 7'h24;
      5'h03: glyph = 7'h30;  5'h04: glyph = 7'h19;  5'h05: glyph = 7'h12;
      5'h06: glyph = 7'h02;  5'h07: glyph = 7'h78;  5'h08: glyph = 7'h00;
      5'h09: glyph = 7'h10;  5'h0A: glyph = 7'h08;  5'h0B: glyph = 7'h03;
      5'h0C: glyph = 7'h46;  5'h0D: glyph = 7'h21;  5'h0E: glyph = 7'h06;
      5'h0F: glyph = 7'h0E;  5'h11: glyph = 7'h61;  5'h12: glyph = 7'h12;
      5'h13: glyph = 7'h07;  5'h14: glyph = 7'h41;  5'h15: glyph = 7'h0C;
      5'h16: glyph = 7'h42;  5'h17: glyph = 7'h47;  5'h18: glyph = 7'h11;
      5'h19: glyph = 7'h2B;  default: glyph = 7'h7F;
    endcase
  endfunction

  // Expected outputs are pushed at each edge and popped just after it.
  always @(posedge clock) begin
    exp_t       e, got;
    int         slot, di;
    bit         ph, bnd, dark;
    logic [7:0] onehot;
    if (reset) begin
      e   = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
      cyc = 0;
      m_pv = 0;
      m_dp = '0;
      m_blink = '0;
      for (int k = 0; k < 8; k++) m_act[k] = 5'h10;
    end else begin
      slot   = cyc % 8;
      di     = (cyc / 8) % 8;
      ph     = ((cyc / 64) % 2) == 1;
      bnd    = (cyc % 64) == 63;
      dark   = (slot < 2) || (ph && m_blink[di]);
      onehot = 8'h01 << di;
      e.an   = dark ? 8'hFF : ~onehot;
      e.seg  = dark ? 7'h7F : glyph(m_act[di]);
      e.dp   = dark ? 1'b1 : ~m_dp[di];
      e.fd   = bnd;
      if (load) begin
        for (int k = 0; k < 8; k++) begin
          if (bnd) m_act[k] = chars_in[5*k +: 5];
          else     m_pend[k] = chars_in[5*k +: 5];
        end
        if (bnd) begin m_dp = dp_in; m_blink = blink_in; m_pv = 0; end
        else     begin m_pdp = dp_in; m_pblink = blink_in; m_pv = 1; end
      end else if (bnd && m_pv) begin
        for (int k = 0; k < 8; k++) m_act[k] = m_pend[k];
        m_dp = m_pdp;
        m_blink = m_pblink;
        m_pv = 0;
      end
      cyc++;
    end
    q.push_back(e);
    #1;
    got = q.pop_front();
    chk("an", 32'(an), 32'(got.an));
    chk("seg", 32'(seg), 32'(got.seg));
    chk("dp", 32'(dp), 32'(got.dp));
    chk("frame_done", 32'(frame_done), 32'(got.fd));
  end

  task automatic do_load(input logic [4:0] codes [8], input logic [7:0] d, input logic [7:0] b);
    for (int k = 0; k < 8; k++) chars_in[5*k +: 5] = codes[k];
    dp_in    = d;
    blink_in = b;
    load     = 1'b1;
    @(negedge clock);
    load     = 1'b0;
  endtask

  task automatic wait_state(input int n);
    int guard_cnt = 0;
    while ((cyc % 64) != n && guard_cnt < 200) begin
      @(negedge clock);
      guard_cnt++;
    end
    chk("wait_state", 32'(cyc % 64), 32'(n));
  endtask

  task automatic fill(output logic [4:0] codes [8], input logic [4:0] c);
    for (int k = 0; k < 8; k++) codes[k] = c;
  endtask

  initial begin
    logic [4:0] codes [8];
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_pend", 32'(dut.pend_valid), 32'd0);

    // All 8s: blank until the first boundary, then full glyphs.
    repeat (5) @(negedge clock);
    fill(codes, 5'h08);
    do_load(codes, 8'h00, 8'h00);
    chk("pend_set", 32'(dut.pend_valid), 32'd1);
    repeat (140) @(negedge clock);

    // "J1 SETUP", leftmost character in digit 7.
    codes[7] = 5'h11; codes[6] = 5'h01; codes[5] = 5'h10; codes[4] = 5'h12;
    codes[3] = 5'h0E; codes[2] = 5'h13; codes[1] = 5'h14; codes[0] = 5'h15;
    wait_state(20);
    do_load(codes, 8'h40, 8'h00);
    repeat (140) @(negedge clock);

    // Two loads in one frame: only the second may ever appear.
    wait_state(24);
    fill(codes, 5'h0A);
    do_load(codes, 8'hFF, 8'h00);
    wait_state(40);
    fill(codes, 5'h0B);
    do_load(codes, 8'h00, 8'h00);
    repeat (140) @(negedge clock);

    // Load exactly on the boundary cycle.
    wait_state(63);
    for (int k = 0; k < 8; k++) codes[k] = 5'(k);
    do_load(codes, 8'h81, 8'h00);
    chk("pend_boundary", 32'(dut.pend_valid), 32'd0);
    repeat (70) @(negedge clock);

    // Blink digit 0 only.
    wait_state(10);
    do_load(codes, 8'h00, 8'h01);
    repeat (300) @(negedge clock);

    // Reset during slot 4 with a load pending.
    wait_state(16);
    fill(codes, 5'h02);
    do_load(codes, 8'h0F, 8'h00);
    chk("pend_before_rst", 32'(dut.pend_valid), 32'd1);
    wait_state(34);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("pend_after_rst", 32'(dut.pend_valid), 32'd0);
    repeat (140) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
